serial_pattern_generator: RTL and testbench
===========================================

# serial_pattern_generator

Transmit-side counterpart of the sequence detector: accepts 4-bit words over a valid/ready handshake, buffers them in a small FIFO and shifts them out one bit per clock, bit 0 first, on a single serial line. It drives the detector's `in` input in integration tests and on the board, replacing hand-written per-bit stimulus loops. A `hold` input lets the consumer stall the stream without losing bits.

## Interface
- `WIDTH`, default 4: bits per word.
- `DEPTH`, default 2: FIFO entries; power of two, ≥2.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `data` in WIDTH: word to transmit; `data[0]` is sent first.
- `data_valid` in 1: `data` is offered this cycle.
- `data_ready` out 1: combinational `!fifo_full`; a word is accepted on a rising edge where `data_valid && data_ready`.
- `hold` in 1: stall the serializer.
- `out` out 1: serial bit, registered.
- `out_valid` out 1: `out` carries a word bit this cycle, registered.
- `frame_start` out 1: high with `out_valid` while bit 0 of a word is driven, registered.
- `busy` out 1: FIFO non-empty or FSM not in IDLE.
- `state` out 4: FSM state code, for debug and bench.

## Operation
- Reset (async, immediate): FIFO emptied, FSM to IDLE, bit counter 0.
  - `out`, `out_valid`, `frame_start`, `busy`, `state` = 0.
  - `data_ready` = 1, but pushes while `rst_n`=0 are discarded.
- FSM states: IDLE=4'd0, SHIFT=4'd1, HOLD=4'd2.
- IDLE:
  - FIFO non-empty and `hold`=0 → pop into shift register, cnt=0, go SHIFT.
  - Otherwise stay; `out_valid`=0.
- SHIFT: each edge drives `out`=sreg[cnt], `out_valid`=1, `frame_start`=(cnt==0).
  - `hold`=1 → go HOLD without advancing cnt; the bit is not emitted this cycle.
  - cnt==WIDTH-1 and FIFO non-empty → pop the next word, cnt=0, stay SHIFT (no gap).
  - cnt==WIDTH-1 and FIFO empty → go IDLE.
  - Otherwise cnt+1.
- HOLD: `out_valid`=0, `frame_start`=0, `out` keeps its last value.
  - `hold`=0 → SHIFT, resuming at the same cnt.
- FIFO push and pop in the same cycle are both honoured; the count is unchanged.
- No bypass: a push into an empty FIFO is not visible to the pop until the next edge.
- cnt is $clog2(WIDTH) bits wide and never wraps past WIDTH-1.
- FIFO pointers wrap modulo DEPTH; full/empty come from a count of $clog2(DEPTH)+1 bits.
- Reset mid-word: the partial word and all queued words are dropped; nothing is replayed.

## Timing
- Latency into an idle, empty block with `hold`=0:
  - Word accepted at edge N, popped at edge N+1.
  - Bit 0 is on `out` with `out_valid`=1 after edge N+2.
  - Bit WIDTH-1 is on `out` after edge N+1+WIDTH.
- Sustained throughput: 1 bit/cycle, i.e. one word per WIDTH cycles with back-to-back words.
- `hold` is sampled at the edge; asserting it for k cycles inserts exactly k cycles with `out_valid`=0.
- `data_ready` falls in the same cycle the FIFO count reaches DEPTH.

## Structure
- Package `serial_gen_pkg`:
  - state enum: IDLE, SHIFT, HOLD, with 4-bit encoding.
  - default WIDTH and DEPTH localparams.
- Sub-module `seq_word_fifo`: parameterized synchronous FIFO with async active-low reset; provides push, pop, full and empty.
- Top level: FSM, shift register, bit counter and output registers.

## Test plan
- Reset, then push 4'b1011 → `out`=1,1,0,1 on 4 consecutive `out_valid` cycles; `frame_start` on the first only; `busy` returns to 0 after.
- Push 4'b0001 then 4'b1000 back-to-back → 8 contiguous valid bits 1,0,0,0,0,0,0,1; `frame_start` on bits 0 and 4.
- `hold`=1 from reset, push 3 words → first two accepted; `data_ready`=0 and the third is refused; release `hold` → 8 bits out, then `data_ready`=1.
- Word 4'b0110, `hold`=1 for 3 cycles at bit 2 → `out_valid` low 3 cycles; stream resumes with bit 2 (=1), then bit 3 (=0).
- Drop `rst_n` during bit 1 of 4'b1111 with one word queued → all outputs 0 immediately; nothing emitted after release until a new push.
- Push 4'd1..4'd15 continuously, output looped into the sequence detector → 60 contiguous bits matching each word LSB-first; detector `dec` matches the golden model.

Source files
------------

// File: rtl/serial_gen_pkg.sv
// Shared definitions for the serial pattern generator.
// Contents: FSM state enum with a 4-bit encoding and the default word/FIFO sizes.
package serial_gen_pkg;

    localparam int DEFAULT_WIDTH = 4;
    localparam int DEFAULT_DEPTH = 2;

    typedef enum logic [3:0] {
        IDLE  = 4'd0,
        SHIFT = 4'd1,
        HOLD  = 4'd2
    } state_e;

endpackage

// File: rtl/serial_pattern_generator_if.sv
// Word-in / bit-out bus of the serial pattern generator.
// Producer side: data, data_valid, hold in; data_ready back.
// Serial side:   out, out_valid, frame_start from the generator.
// master = word producer / serial consumer, slave = the generator itself.
interface serial_pattern_generator_if
    import serial_gen_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic [WIDTH-1:0] data;
    logic             data_valid;
    logic             data_ready;
    logic             hold;
    logic             out;
    logic             out_valid;
    logic             frame_start;

    modport master (
        output data,
        output data_valid,
        output hold,
        input  data_ready,
        input  out,
        input  out_valid,
        input  frame_start
    );

    modport slave (
        input  data,
        input  data_valid,
        input  hold,
        output data_ready,
        output out,
        output out_valid,
        output frame_start
    );
endinterface

// File: rtl/seq_word_fifo.sv
// Small synchronous word FIFO with asynchronous active-low reset.
// Ports: clk, rst_n; i_push/i_wdata write side; i_pop/o_rdata read side
// (o_rdata shows the head word combinationally); o_full, o_empty status.
// A push into an empty FIFO only becomes visible on the following edge.
module seq_word_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_full;
    logic             w_empty;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign w_full    = (r_count == CNT_W'(DEPTH));
    assign w_empty   = (r_count == {CNT_W{1'b0}});
    assign w_push_ok = i_push && !w_full;
    assign w_pop_ok  = i_pop && !w_empty;
    assign o_full    = w_full;
    assign o_empty   = w_empty;
    assign o_rdata   = r_mem[r_rd_ptr];

    // Storage array and write pointer; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= {WIDTH{1'b0}};
            end
            r_wr_ptr <= {PTR_W{1'b0}};
        end else begin
            if (w_push_ok) begin
                r_mem[r_wr_ptr] <= i_wdata;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
        end
    end

    // Read pointer and occupancy count; simultaneous push and pop leave the count unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= {PTR_W{1'b0}};
            r_count  <= {CNT_W{1'b0}};
        end else begin
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: rtl/serial_pattern_generator.sv
// Serial pattern generator: buffers WIDTH-bit words in a FIFO and shifts them
// out LSB first, one bit per clock, with no gap between queued words.
// Ports: clk, rst_n (async, active-low); bus (slave modport: data/data_valid/
// data_ready handshake, hold stall input, out/out_valid/frame_start serial
// outputs); busy (FIFO non-empty or FSM active); state (FSM code for debug).
module serial_pattern_generator
    import serial_gen_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                        clk,
    input  logic                        rst_n,
    serial_pattern_generator_if.slave   bus,
    output logic                        busy,
    output logic [3:0]                  state
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    localparam logic [3:0] ST_IDLE  = IDLE;
    localparam logic [3:0] ST_SHIFT = SHIFT;
    localparam logic [3:0] ST_HOLD  = HOLD;

    logic [3:0]       r_state;
    logic [WIDTH-1:0] r_sreg;
    logic [CNT_W-1:0] r_cnt;
    logic             r_out;
    logic             r_out_valid;
    logic             r_frame_start;

    logic [3:0]       w_state_nxt;
    logic [WIDTH-1:0] w_sreg_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_out_nxt;
    logic             w_out_valid_nxt;
    logic             w_frame_start_nxt;
    logic             w_pop;
    logic             w_push;
    logic [WIDTH-1:0] w_fifo_rdata;
    logic             w_fifo_full;
    logic             w_fifo_empty;

    assign w_push = bus.data_valid && !w_fifo_full;

    seq_word_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_wdata (bus.data),
        .i_pop   (w_pop),
        .o_rdata (w_fifo_rdata),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    // Next-state logic. HOLD with hold released behaves exactly like SHIFT so
    // that k cycles of hold cost exactly k idle output cycles.
    always_comb begin
        w_state_nxt       = r_state;
        w_sreg_nxt        = r_sreg;
        w_cnt_nxt         = r_cnt;
        w_out_nxt         = r_out;
        w_out_valid_nxt   = 1'b0;
        w_frame_start_nxt = 1'b0;
        w_pop             = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_fifo_empty && !bus.hold) begin
                    w_pop       = 1'b1;
                    w_sreg_nxt  = w_fifo_rdata;
                    w_cnt_nxt   = {CNT_W{1'b0}};
                    w_state_nxt = ST_SHIFT;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SHIFT, ST_HOLD: begin
                if (bus.hold) begin
                    w_state_nxt = ST_HOLD;
                end else begin
                    w_out_nxt         = r_sreg[r_cnt];
                    w_out_valid_nxt   = 1'b1;
                    w_frame_start_nxt = (r_cnt == {CNT_W{1'b0}});
                    if (r_cnt == CNT_LAST) begin
                        w_cnt_nxt = {CNT_W{1'b0}};
                        if (!w_fifo_empty) begin
                            // Chain the next word straight in, no idle bit between words.
                            w_pop       = 1'b1;
                            w_sreg_nxt  = w_fifo_rdata;
                            w_state_nxt = ST_SHIFT;
                        end else begin
                            w_state_nxt = ST_IDLE;
                        end
                    end else begin
                        w_cnt_nxt   = r_cnt + CNT_W'(1);
                        w_state_nxt = ST_SHIFT;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = {CNT_W{1'b0}};
            end
        endcase
    end

    // FSM, shift register, bit counter and registered serial outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_sreg        <= {WIDTH{1'b0}};
            r_cnt         <= {CNT_W{1'b0}};
            r_out         <= 1'b0;
            r_out_valid   <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_sreg        <= w_sreg_nxt;
            r_cnt         <= w_cnt_nxt;
            r_out         <= w_out_nxt;
            r_out_valid   <= w_out_valid_nxt;
            r_frame_start <= w_frame_start_nxt;
        end
    end

    assign bus.data_ready  = !w_fifo_full;
    assign bus.out         = r_out;
    assign bus.out_valid   = r_out_valid;
    assign bus.frame_start = r_frame_start;
    assign busy            = !w_fifo_empty || (r_state != ST_IDLE);
    assign state           = r_state;
endmodule

// File: tb/tb_serial_pattern_generator.sv
// Self-checking bench for serial_pattern_generator: table-driven cycle
// vectors plus hand-written reset-mid-word and long-stream sequences.
module tb_serial_pattern_generator;

    logic       clk;
    logic       rst_n;
    logic       busy;
    logic [3:0] state;

    int n_checks;
    int n_errors;

    serial_pattern_generator_if #(.WIDTH(4)) bus ();

    serial_pattern_generator #(.WIDTH(4), .DEPTH(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave),
        .busy  (busy),
        .state (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock step: inputs applied before the edge, expectations sampled after it.
    // exp = {data_ready, out, out_valid, frame_start, busy}
    typedef struct {
        bit       rst;
        logic [3:0] data;
        bit       dv;
        bit       hold;
        logic [4:0] exp;
        logic [3:0] st;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input bit r, input logic [3:0] d, input bit dv, input bit h,
                                input logic [4:0] e, input logic [3:0] s);
        vec_t v;
        v.rst = r; v.data = d; v.dv = dv; v.hold = h; v.exp = e; v.st = s;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        bus.data       = 4'd0;
        bus.data_valid = 1'b0;
        bus.hold       = 1'b0;
        rst_n          = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n          = 1'b0;
        bus.data       = 4'd0;
        bus.data_valid = 1'b0;
        bus.hold       = 1'b0;

        // Single word 1011 -> 1,1,0,1
        vecs.push_back(mk(1'b1, 4'b1011, 1'b1, 1'b0, 5'b10001, 4'd0));
        vecs.push_back(mk(1'b0, 4'b0000, 1'b0, 1'b0, 5'b10001, 4'd1));
        vecs.push_back(mk(1'b0, 4'b0000, 1'b0, 1'b0, 5'b11111, 4'd1));
        vecs.push_back(mk(1'b0, 4'b0000, 1'b0, 1'b0, 5'b11101, 4'd1));
        vecs.push_back(mk(1'b0, 4'b0000, 1'b0, 1'b0, 5'b10101, 4'd1));
        vecs.push_back(mk(1'b0, 4'b0000, 1'b0, 1'b0, 5'b11100, 4'd0));
        vecs.push_back(mk(1'b0, 4'b0000, 1'b0, 1'b0, 5'b11000, 4'd0));
        // Back-to-back 0001, 1000 -> 1,0,0,0,0,0,0,1 with no gap
        vecs.push_back(mk(1'b1, 4'b0001, 1'b1, 1'b0, 5'b10001, 4'd0));
        vecs.push_back(mk(1'b0, 4'b1000, 1'b1, 1'b0, 5'b10001, 4'd1));
        vecs.push_back(mk(1'b0, 4'b0000, 1'b0, 1'b0, 5'b11111, 4'd1));
        vecs.push_back(mk(1'b0, 4'b0000, 1'b0, 1'b0, 5'b10101, 4'd1));
        vecs.push_back(mk(1'b0, 4'b0000, 1'b0, 1'b0, 5'b10101, 4'd1));
        vecs.push_back(mk(1'b0, 4'b0000, 1'b0, 1'b0, 5'b10101, 4'd1));
        vecs.push_back(mk(1'b0, 4'b0000, 1'b0, 1'b0, 5'b10111, 4'd1));
        vecs.push_back(mk(1'b0, 4'b0000, 1'b0, 1'b0, 5'b10101, 4'd1));
        vecs.push_back(mk(1'b0, 4'b0000, 1'b0, 1'b0, 5'b10101, 4'd1));
        vecs.push_back(mk(1'b0, 4'b0000, 1'b0, 1'b0, 5'b11100, 4'd0));
        vecs.push_back(mk(1'b0, 4'b0000, 1'b0, 1'b0, 5'b11000, 4'd0));
        // Hold from reset: 0011, 0101 accepted, 1111 refused while full
        vecs.push_back(mk(1'b1, 4'b0011, 1'b1, 1'b1, 5'b10001, 4'd0));
        vecs.push_back(mk(1'b0, 4'b0101, 1'b1, 1'b1, 5'b00001, 4'd0));
        vecs.push_back(mk(1'b0, 4'b1111, 1'b1, 1'b1, 5'b00001, 4'd0));
        vecs.push_back(mk(1'b0, 4'b1111, 1'b0, 1'b0, 5'b10001, 4'd1));
        vecs.push_back(mk(1'b0, 4'b0000, 1'b0, 1'b0, 5'b11111, 4'd1));
        vecs.push_back(mk(1'b0, 4'b0000, 1'b0, 1'b0, 5'b11101, 4'd1));
        vecs.push_back(mk(1'b0, 4'b0000, 1'b0, 1'b0, 5'b10101, 4'd1));
        vecs.push_back(mk(1'b0, 4'b0000, 1'b0, 1'b0, 5'b10101, 4'd1));
        vecs.push_back(mk(1'b0, 4'b0000, 1'b0, 1'b0, 5'b11111, 4'd1));
        vecs.push_back(mk(1'b0, 4'b0000, 1'b0, 1'b0, 5'b10101, 4'd1));
        vecs.push_back(mk(1'b0, 4'b0000, 1'b0, 1'b0, 5'b11101, 4'd1));
        vecs.push_back(mk(1'b0, 4'b0000, 1'b0, 1'b0, 5'b10100, 4'd0));
        vecs.push_back(mk(1'b0, 4'b0000, 1'b0, 1'b0, 5'b10000, 4'd0));
        // 0110 with hold for 3 cycles at bit 2
        vecs.push_back(mk(1'b1, 4'b0110, 1'b1, 1'b0, 5'b10001, 4'd0));
        vecs.push_back(mk(1'b0, 4'b0000, 1'b0, 1'b0, 5'b10001, 4'd1));
        vecs.push_back(mk(1'b0, 4'b0000, 1'b0, 1'b0, 5'b10111, 4'd1));
        vecs.push_back(mk(1'b0, 4'b0000, 1'b0, 1'b0, 5'b11101, 4'd1));
        vecs.push_back(mk(1'b0, 4'b0000, 1'b0, 1'b1, 5'b11001, 4'd2));
        vecs.push_back(mk(1'b0, 4'b0000, 1'b0, 1'b1, 5'b11001, 4'd2));
        vecs.push_back(mk(1'b0, 4'b0000, 1'b0, 1'b1, 5'b11001, 4'd2));
        vecs.push_back(mk(1'b0, 4'b0000, 1'b0, 1'b0, 5'b11101, 4'd1));
        vecs.push_back(mk(1'b0, 4'b0000, 1'b0, 1'b0, 5'b10100, 4'd0));
        vecs.push_back(mk(1'b0, 4'b0000, 1'b0, 1'b0, 5'b10000, 4'd0));

        // Reset state
        #2;
        chk("rst.ready", 32'(bus.data_ready), 32'd1);
        chk("rst.out", 32'(bus.out), 32'd0);
        chk("rst.out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst.frame_start", 32'(bus.frame_start), 32'd0);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.state", 32'(state), 32'd0);

        // Table-driven vectors
        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].rst) do_reset();
            bus.data       = vecs[i].data;
            bus.data_valid = vecs[i].dv;
            bus.hold       = vecs[i].hold;
            @(posedge clk); #1;
            chk($sformatf("v%0d.ready", i), 32'(bus.data_ready), 32'(vecs[i].exp[4]));
            chk($sformatf("v%0d.out", i), 32'(bus.out), 32'(vecs[i].exp[3]));
            chk($sformatf("v%0d.out_valid", i), 32'(bus.out_valid), 32'(vecs[i].exp[2]));
            chk($sformatf("v%0d.frame_start", i), 32'(bus.frame_start), 32'(vecs[i].exp[1]));
            chk($sformatf("v%0d.busy", i), 32'(busy), 32'(vecs[i].exp[0]));
            chk($sformatf("v%0d.state", i), 32'(state), 32'(vecs[i].st));
        end

        // Reset during bit 1 of 1111 with 1010 queued
        begin
            int stray;
            do_reset();
            bus.data = 4'b1111; bus.data_valid = 1'b1;
            @(posedge clk); #1;
            bus.data = 4'b1010;
            @(posedge clk); #1;
            bus.data_valid = 1'b0;
            @(posedge clk); #1;
            @(posedge clk); #1;
            chk("mid.bit1_valid", 32'(bus.out_valid), 32'd1);
            chk("mid.bit1_out", 32'(bus.out), 32'd1);
            #2;
            rst_n = 1'b0;
            bus.data = 4'b0101; bus.data_valid = 1'b1;
            #1;
            chk("mid.out", 32'(bus.out), 32'd0);
            chk("mid.out_valid", 32'(bus.out_valid), 32'd0);
            chk("mid.frame_start", 32'(bus.frame_start), 32'd0);
            chk("mid.busy", 32'(busy), 32'd0);
            chk("mid.state", 32'(state), 32'd0);
            chk("mid.ready", 32'(bus.data_ready), 32'd1);
            @(posedge clk); #1;
            @(posedge clk); #1;
            rst_n = 1'b1;
            bus.data_valid = 1'b0;
            stray = 0;
            for (int c = 0; c < 10; c++) begin
                @(posedge clk); #1;
                if (bus.out_valid || busy) stray++;
            end
            chk("mid.no_replay", 32'(stray), 32'd0);
        end

        // Continuous stream of words 1..15: 60 contiguous LSB-first bits
        begin
            int  next_w;
            int  nbits;
            int  gaps;
            bit  started;
            bit  acc;
            logic [3:0] w;
            logic [31:0] wv;
            do_reset();
            next_w = 1;
            nbits = 0;
            gaps = 0;
            started = 1'b0;
            bus.data = 4'd1; bus.data_valid = 1'b1;
            for (int cyc = 0; cyc < 200 && nbits < 60; cyc++) begin
                acc = bus.data_valid && bus.data_ready;
                @(posedge clk); #1;
                if (acc) next_w++;
                if (bus.out_valid) begin
                    wv = 32'(nbits / 4 + 1);
                    w  = wv[3:0];
                    chk($sformatf("stream.w%0d.b%0d", nbits / 4 + 1, nbits % 4),
                        32'(bus.out), 32'(w[nbits % 4]));
                    chk($sformatf("stream.fs%0d", nbits), 32'(bus.frame_start),
                        32'((nbits % 4) == 0));
                    nbits++;
                    started = 1'b1;
                end else if (started) begin
                    gaps++;
                end
                if (next_w <= 15) begin
                    wv = 32'(next_w);
                    bus.data = wv[3:0];
                    bus.data_valid = 1'b1;
                end else begin
                    bus.data_valid = 1'b0;
                end
            end
            chk("stream.bits", 32'(nbits), 32'd60);
            chk("stream.gaps", 32'(gaps), 32'd0);
            @(posedge clk); #1;
            chk("stream.idle_busy", 32'(busy), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
